// File: rtl/parity_sched_pkg.sv
// parity_sched_pkg: shared widths, FSM state encoding and parity mode constants
package parity_sched_pkg;
    localparam int DATA_W  = 7;
    localparam int FRAME_W = 8;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;
endpackage

// File: rtl/parity_frame_gen.sv
// parity_frame_gen: builds {data, parity} with even or odd parity
module parity_frame_gen
    import parity_sched_pkg::*;
(
    input  logic [DATA_W-1:0]  data,
    input  logic               odd,
    output logic [FRAME_W-1:0] frame
);
    assign frame = {data, (odd == PAR_ODD) ? ~^data : ^data};
endmodule

// File: rtl/parity_tx_sched.sv
// parity_tx_sched: round-robin parity frame serializer; TX_FRAME_CNT_EN adds frame_cnt
module parity_tx_sched
    import parity_sched_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int GAP_CYCLES = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [7*NUM_REQ-1:0]    req_data,
    input  logic [NUM_REQ-1:0]      req_odd,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    ser_out,
    output logic                    ser_valid,
    output logic                    ser_last,
    output logic [1:0]              ser_src,
    output logic                    busy
`ifdef TX_FRAME_CNT_EN
    , output logic [15:0]           frame_cnt
`endif
);
    state_t               state_q, state_d;
    logic [1:0]           rr_ptr_q, rr_ptr_d, ser_src_q, ser_src_d, g;
    logic [FRAME_W-1:0]   shreg_q, shreg_d, frame;
    logic [3:0]           cnt_q, cnt_d;
    logic                 ser_out_q, ser_out_d, ser_valid_q, ser_valid_d, ser_last_q, ser_last_d;
    logic                 found, sel_odd;
    logic [DATA_W-1:0]    sel_data;

    // search order starts just after the last winner
    always_comb begin
        found    = 1'b0;
        g        = 2'd0;
        sel_data = '0;
        sel_odd  = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && req_valid[i] && ((int'(rr_ptr_q) + k) % NUM_REQ) == i) begin
                    found    = 1'b1;
                    g        = 2'(i);
                    sel_data = req_data[7*i +: 7];
                    sel_odd  = req_odd[i];
                end
            end
        end
    end

    parity_frame_gen u_gen (
        .data  (sel_data),
        .odd   (sel_odd),
        .frame (frame)
    );

    assign req_ready = (state_q == ST_IDLE && found) ? (NUM_REQ'(1) << g) : '0;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        ser_src_d   = ser_src_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        ser_out_d   = 1'b0;
        ser_valid_d = 1'b0;
        ser_last_d  = 1'b0;
        if (state_q == ST_IDLE && found) begin
            state_d     = ST_SHIFT;
            shreg_d     = frame << 1;
            ser_src_d   = g;
            rr_ptr_d    = g;
            cnt_d       = 4'd7;
            ser_out_d   = frame[7];
            ser_valid_d = 1'b1;
        end else if (state_q == ST_SHIFT && cnt_q != 4'd0) begin
            shreg_d     = shreg_q << 1;
            cnt_d       = cnt_q - 4'd1;
            ser_out_d   = shreg_q[7];
            ser_valid_d = 1'b1;
            ser_last_d  = (cnt_q == 4'd1);
        end else if (state_q == ST_SHIFT) begin
            state_d = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
            cnt_d   = 4'(GAP_CYCLES - 1);
        end else if (state_q == ST_GAP) begin
            state_d = (cnt_q == 4'd0) ? ST_IDLE : ST_GAP;
            cnt_d   = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= 2'(NUM_REQ - 1);
            ser_src_q   <= 2'd0;
            shreg_q     <= '0;
            cnt_q       <= 4'd0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            ser_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            ser_src_q   <= ser_src_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            ser_last_q  <= ser_last_d;
        end
    end

    assign ser_out   = ser_out_q;
    assign ser_valid = ser_valid_q;
    assign ser_last  = ser_last_q;
    assign ser_src   = ser_src_q;
    assign busy      = (state_q != ST_IDLE);

`ifdef TX_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;
    always_comb frame_cnt_d = frame_cnt_q + {15'd0, ser_last_q};
    always_ff @(posedge clk) begin
        if (rst) frame_cnt_q <= 16'd0;
        else     frame_cnt_q <= frame_cnt_d;
    end
    assign frame_cnt = frame_cnt_q;
`endif
endmodule

// File: tb/tb_parity_tx_sched.sv
// tb_parity_tx_sched: randomized and directed checks against a frame-position reference model
module tb_parity_tx_sched;
    localparam int N   = 2;
    localparam int GAP = 1;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid, req_odd, req_ready;
    logic [7*N-1:0] req_data;
    logic           ser_out, ser_valid, ser_last, busy;
    logic [1:0]     ser_src;
`ifdef TX_FRAME_CNT_EN
    logic [15:0]    frame_cnt;
`endif

    always #5 clk = ~clk;

    parity_tx_sched #(.NUM_REQ(N), .GAP_CYCLES(GAP)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_odd   (req_odd),
        .req_ready (req_ready),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .ser_last  (ser_last),
        .ser_src   (ser_src),
        .busy      (busy)
`ifdef TX_FRAME_CNT_EN
        , .frame_cnt (frame_cnt)
`endif
    );

    int total = 0, bad = 0, cyc = 0;
    int pos = 0, mrr = N - 1, msrc = 0, g = -1, last_g = -1;
    logic [7:0] mframe = '0, rx = '0;
    int rx_src = 0;
    int grants[$], gcyc[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_frame(input logic [6:0] d, input logic odd);
        return {d, 1'(($countones(d) & 1) ^ int'(odd))};
    endfunction

    function automatic int pick(input logic [N-1:0] v, input int rr);
        for (int k = 1; k <= N; k++)
            if (v[(rr + k) % N]) return (rr + k) % N;
        return -1;
    endfunction

    // pos: 0 idle, 1..8 frame bit slots, 9..8+GAP inter-frame gap
    task automatic step(input logic r, input logic [N-1:0] v, input logic [7*N-1:0] d, input logic [N-1:0] o);
        @(negedge clk);
        check("ser_valid", ser_valid, pos >= 1 && pos <= 8);
        check("ser_last", ser_last, pos == 8);
        check("busy", busy, pos != 0);
        if (pos >= 1 && pos <= 8) begin
            check("ser_out", ser_out, mframe[8-pos]);
            check("ser_src", ser_src, msrc);
            rx = {rx[6:0], ser_out};
            rx_src = ser_src;
        end
        rst = r; req_valid = v; req_data = d; req_odd = o;
        #1;
        g = (pos == 0) ? pick(v, mrr) : -1;
        check("req_ready", req_ready, (g < 0) ? 0 : (1 << g));
        @(posedge clk);
        cyc++;
        if (r) begin
            pos = 0; mrr = N - 1; g = -1;
        end else if (g >= 0) begin
            mframe = ref_frame(d[7*g +: 7], o[g]);
            msrc = g; mrr = g; pos = 1;
            grants.push_back(g); gcyc.push_back(cyc);
        end else if (pos > 0) begin
            pos = (pos >= 8 + GAP) ? 0 : pos + 1;
        end
        last_g = g;
    endtask

    task automatic send(input int i, input logic [6:0] d, input logic o, input logic [7:0] exp, input string tag);
        logic [N-1:0]   v  = N'(1) << i;
        logic [7*N-1:0] dd = '0;
        logic [N-1:0]   oo = '0;
        int k = 0;
        dd[7*i +: 7] = d;
        oo[i] = o;
        last_g = -1;
        while (last_g != i && k < 40) begin
            step(1'b0, v, dd, oo);
            k++;
        end
        check({tag, "_grant"}, last_g == i, 1);
        repeat (8) step(1'b0, '0, '0, '0);
        check({tag, "_frame"}, rx, exp);
        check({tag, "_src"}, rx_src, i);
        repeat (1 + GAP) step(1'b0, '0, '0, '0);
    endtask

    initial begin
        logic [N-1:0]   cv = '0, co = '0;
        logic [7*N-1:0] cd = '0;
        rst = 1'b1; req_valid = '0; req_data = '0; req_odd = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", req_ready, 0);
        check("rst_out", ser_out, 0);
        check("rst_valid", ser_valid, 0);
        check("rst_last", ser_last, 0);
        check("rst_src", ser_src, 0);
        check("rst_busy", busy, 0);

        send(0, 7'h55, 1'b0, 8'hAA, "even55");
        send(1, 7'h55, 1'b1, 8'hAB, "odd55");
        send(0, 7'h01, 1'b0, 8'h03, "even01");
        send(1, 7'h00, 1'b1, 8'h01, "odd00");
        send(0, 7'h7F, 1'b0, 8'hFF, "even7f");

        // abandon a frame from requester 0 on its 4th bit
        last_g = -1;
        for (int k = 0; k < 40 && last_g != 0; k++) step(1'b0, 2'b01, 14'h0033, 2'b00);
        check("rst_mid_grant", last_g, 0);
        repeat (3) step(1'b0, '0, '0, '0);
        step(1'b1, '0, '0, '0);
        #1;
        check("rst_mid_valid", ser_valid, 0);
        check("rst_mid_last", ser_last, 0);
        check("rst_mid_busy", busy, 0);

        grants.delete(); gcyc.delete();
        repeat (42) step(1'b0, 2'b11, {7'h11, 7'h22}, 2'b01);
        check("rr_count", grants.size() >= 4, 1);
        if (grants.size() >= 4) begin
            for (int k = 0; k < 4; k++) check("rr_order", grants[k], k % 2);
            for (int k = 1; k < 4; k++) check("rr_spacing", gcyc[k] - gcyc[k-1], 9 + GAP);
        end
        repeat (12) step(1'b0, '0, '0, '0);

`ifdef TX_FRAME_CNT_EN
        step(1'b1, '0, '0, '0);
        send(0, 7'h12, 1'b0, ref_frame(7'h12, 1'b0), "cnt_a");
        send(1, 7'h34, 1'b1, ref_frame(7'h34, 1'b1), "cnt_b");
        send(0, 7'h56, 1'b0, ref_frame(7'h56, 1'b0), "cnt_c");
        check("frame_cnt3", frame_cnt, 3);
        @(negedge clk);
        force dut.frame_cnt_q = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.frame_cnt_q;
        check("frame_cnt_ff", frame_cnt, 16'hFFFF);
        send(1, 7'h2A, 1'b0, ref_frame(7'h2A, 1'b0), "cnt_wrap");
        check("frame_cnt_wrap", frame_cnt, 0);
`endif

        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++) begin
                if (cv[i] && last_g != i) begin
                    if ($urandom_range(0, 15) == 0) cv[i] = 1'b0;
                end else begin
                    cv[i] = ($urandom_range(0, 2) != 0);
                    cd[7*i +: 7] = 7'($urandom);
                    co[i] = 1'($urandom);
                end
            end
            step($urandom_range(0, 299) == 0, cv, cd, co);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
